pong_ball_engine: RTL
=====================

Name: pong_ball_engine

Overview:
Hardware ball-physics engine for the ping-pong game. It produces the 6-bit ball_x/ball_y coordinates that the Nios system reads through its ball PIO inputs. It reflects the ball off the walls and paddles and pulses a point event when a paddle misses. Paddle positions arrive from the CPU side; point events feed the software score counters.

Parameters:
GRID_W, 64, playfield columns; ball_x range 0..GRID_W-1; maximum 64.
GRID_H, 64, playfield rows; ball_y range 0..GRID_H-1; maximum 64.
PADDLE_H, 8, paddle height in rows.
TICK_DIV, 500000, clock cycles per ball step; minimum 2.
POINT_HOLD, 16, ball steps the ball stays parked in the goal after a point.

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous, active-high reset
enable  in  1  game run; low freezes all state, counters and outputs
serve  in  1  single-cycle serve request
paddle_a_y  in  6  top row of left paddle A (column 0)
paddle_b_y  in  6  top row of right paddle B (column GRID_W-1)
ball_x  out  6  ball column, registered
ball_y  out  6  ball row, registered
score_a_evt  out  1  one-cycle pulse: A scored (B missed)
score_b_evt  out  1  one-cycle pulse: B scored (A missed)
game_state  out  2  0=SERVE_WAIT, 1=RUN, 2=POINT

Behaviour:
- Reset (async, active-high):
  - state = SERVE_WAIT.
  - ball_x = GRID_W/2, ball_y = GRID_H/2.
  - dx = +1, dy = +1.
  - Tick counter = 0, hold counter = 0.
  - Both event pulses are 0.
- Tick counter runs only when enable=1 and state is RUN or POINT. It counts 0..TICK_DIV-1 and wraps. A "step" occurs in the cycle the counter equals TICK_DIV-1.
- All outputs are registered. Position and event updates are visible the cycle after the step cycle.
- SERVE_WAIT:
  - Ball is held at the centre.
  - serve=1 with enable=1 moves to RUN and clears the tick counter.
  - The first step occurs TICK_DIV cycles after the serve cycle.
  - serve is ignored in RUN and POINT, and while enable=0.
- RUN step, Y axis, evaluated first:
  - If (dy=+1 and y=GRID_H-1) or (dy=-1 and y=0), negate dy.
  - Then y = y + dy. The ball never leaves 0..GRID_H-1.
- RUN step, X axis: paddle-hit checks use the pre-step y.
  - Hit A means paddle_a_y <= y <= paddle_a_y+PADDLE_H-1, computed 7 bits wide with no wrap. A paddle near the bottom is simply clipped by the grid. Hit B is defined the same way with paddle_b_y.
  - dx=-1, x=1, hit A: dx = +1, x = 2.
  - dx=-1, x=1, miss A: x = 0, pulse score_b_evt, go to POINT.
  - dx=+1, x=GRID_W-2, hit B: dx = -1, x = GRID_W-3.
  - dx=+1, x=GRID_W-2, miss B: x = GRID_W-1, pulse score_a_evt, go to POINT.
  - Otherwise: x = x + dx.
- Simultaneous wall and paddle case (corner): the Y reflection and X reflection both apply in the same step.
- POINT:
  - Ball stays parked; y is frozen.
  - After POINT_HOLD steps: go to SERVE_WAIT, centre the ball, set the serve direction.
  - Serve direction is dx = +1 if A scored last (toward B), else -1. dy is retained.
- enable=0 mid-operation freezes everything, including the pulse generation point. Resuming continues exactly where it stopped.
- Reset mid-operation returns to the reset state immediately. A pending event pulse is cleared.
- score_a_evt and score_b_evt are never asserted together. Each is high for exactly one cycle per point.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=4, POINT_HOLD=2.
- Reset release, idle for 20 cycles, no serve:
  - ball_x=32, ball_y=32, game_state=0, no event pulses.
- Serve at cycle 0, paddles far from the ball path:
  - First move to (33,33) is visible at cycle 5.
  - Thereafter one diagonal step every 4 cycles.
- Wall bounce: y=63 with dy=+1 at a step.
  - Next ball_y=62; subsequent steps decrease y.
- Paddle hit: dx=-1, x=1, y=10, paddle_a_y=5.
  - Next x=2 and dx=+1.
  - Repeat with paddle_a_y=3: y=10 is outside 3..10? No, 10 is inside, so this is also a hit.
- Paddle miss, left side: paddle_a_y=20, ball at x=1, y=10, dx=-1.
  - Next x=0 and score_b_evt high for exactly 1 cycle; game_state=2.
  - After 2 further steps: state returns to 0 with ball at (32,32).
  - Next serve moves x to 31.
- Freeze and reset:
  - Drop enable for 10 cycles mid-RUN: ball_x/ball_y and step phase unchanged. On resume, the next step occurs at the same counter phase as before.
  - Assert reset_reset asynchronously mid-RUN: outputs return to (32,32) and state 0 within the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/pong_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : pong_ball_engine
//  Brief    : Ball-physics engine for the ping-pong game. Moves the ball one
//             diagonal cell per step, reflects it off the top/bottom walls
//             and the paddles, and pulses a score event when a paddle misses.
//  Revision : 1.0 - initial release
// ============================================================================
module pong_ball_engine #(
    parameter int GRID_W     = 64,
    parameter int GRID_H     = 64,
    parameter int PADDLE_H   = 8,
    parameter int TICK_DIV   = 500000,
    parameter int POINT_HOLD = 16
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       enable,
    input  logic       serve,
    input  logic [5:0] paddle_a_y,
    input  logic [5:0] paddle_b_y,
    output logic [5:0] ball_x,
    output logic [5:0] ball_y,
    output logic       score_a_evt,
    output logic       score_b_evt,
    output logic [1:0] game_state
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((POINT_HOLD > 0) ? POINT_HOLD - 1 : 0);

    localparam logic [5:0] X_CENTER   = 6'(GRID_W / 2);
    localparam logic [5:0] Y_CENTER   = 6'(GRID_H / 2);
    localparam logic [5:0] X_MAX      = 6'(GRID_W - 1);
    localparam logic [5:0] X_NEAR_B   = 6'(GRID_W - 2);
    localparam logic [5:0] X_BOUNCE_B = 6'(GRID_W - 3);
    localparam logic [5:0] Y_MAX      = 6'(GRID_H - 1);
    localparam logic [6:0] PAD_SPAN   = 7'(PADDLE_H - 1);

    typedef enum logic [1:0] {
        ST_SERVE_WAIT = 2'd0,
        ST_RUN        = 2'd1,
        ST_POINT      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [5:0]          x_q, x_d;
    logic [5:0]          y_q, y_d;
    logic                dx_pos_q, dx_pos_d;   // 1: moving right (+1), 0: left (-1)
    logic                dy_pos_q, dy_pos_d;   // 1: moving down  (+1), 0: up   (-1)
    logic                a_last_q, a_last_d;   // 1: A won the most recent point
    logic                evt_a_q, evt_a_d;
    logic                evt_b_q, evt_b_d;

    logic                step;
    logic                hit_a;
    logic                hit_b;
    logic                dy_next;

    // Step strobe and paddle coverage; paddle range is 7 bits wide so a
    // paddle near the bottom is clipped by the grid instead of wrapping.
    always_comb begin
        step  = enable && (state_q != ST_SERVE_WAIT) && (tick_q == TICK_LAST);
        hit_a = ({1'b0, paddle_a_y} <= {1'b0, y_q}) &&
                ({1'b0, y_q} <= ({1'b0, paddle_a_y} + PAD_SPAN));
        hit_b = ({1'b0, paddle_b_y} <= {1'b0, y_q}) &&
                ({1'b0, y_q} <= ({1'b0, paddle_b_y} + PAD_SPAN));
        if ((dy_pos_q && (y_q == Y_MAX)) || (!dy_pos_q && (y_q == 6'd0))) begin
            dy_next = ~dy_pos_q;
        end else begin
            dy_next = dy_pos_q;
        end
    end

    // Next-state logic: game FSM, tick/hold counters and ball motion.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        hold_d   = hold_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_pos_d = dx_pos_q;
        dy_pos_d = dy_pos_q;
        a_last_d = a_last_q;
        evt_a_d  = evt_a_q;
        evt_b_d  = evt_b_q;

        if (enable) begin
            evt_a_d = 1'b0;
            evt_b_d = 1'b0;
            case (state_q)
                ST_SERVE_WAIT: begin
                    x_d    = X_CENTER;
                    y_d    = Y_CENTER;
                    tick_d = '0;
                    hold_d = '0;
                    if (serve) begin
                        state_d = ST_RUN;
                    end
                end

                ST_RUN: begin
                    tick_d = step ? '0 : tick_q + 1'b1;
                    if (step) begin
                        // Y first: reflect at the walls, then move.
                        dy_pos_d = dy_next;
                        y_d      = dy_next ? y_q + 6'd1 : y_q - 6'd1;
                        // X uses the pre-step y for paddle coverage.
                        if (!dx_pos_q && (x_q == 6'd1)) begin
                            if (hit_a) begin
                                dx_pos_d = 1'b1;
                                x_d      = 6'd2;
                            end else begin
                                x_d      = 6'd0;
                                evt_b_d  = 1'b1;
                                a_last_d = 1'b0;
                                hold_d   = '0;
                                state_d  = ST_POINT;
                            end
                        end else if (dx_pos_q && (x_q == X_NEAR_B)) begin
                            if (hit_b) begin
                                dx_pos_d = 1'b0;
                                x_d      = X_BOUNCE_B;
                            end else begin
                                x_d      = X_MAX;
                                evt_a_d  = 1'b1;
                                a_last_d = 1'b1;
                                hold_d   = '0;
                                state_d  = ST_POINT;
                            end
                        end else begin
                            x_d = dx_pos_q ? x_q + 6'd1 : x_q - 6'd1;
                        end
                    end
                end

                ST_POINT: begin
                    tick_d = step ? '0 : tick_q + 1'b1;
                    if (step) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d  = ST_SERVE_WAIT;
                            hold_d   = '0;
                            x_d      = X_CENTER;
                            y_d      = Y_CENTER;
                            dx_pos_d = a_last_q;   // serve toward the loser
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = ST_SERVE_WAIT;
                end
            endcase
        end
    end

    // State register with asynchronous reset to the centred serve position.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q  <= ST_SERVE_WAIT;
            tick_q   <= '0;
            hold_q   <= '0;
            x_q      <= X_CENTER;
            y_q      <= Y_CENTER;
            dx_pos_q <= 1'b1;
            dy_pos_q <= 1'b1;
            a_last_q <= 1'b0;
            evt_a_q  <= 1'b0;
            evt_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            hold_q   <= hold_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_pos_q <= dx_pos_d;
            dy_pos_q <= dy_pos_d;
            a_last_q <= a_last_d;
            evt_a_q  <= evt_a_d;
            evt_b_q  <= evt_b_d;
        end
    end

    assign ball_x      = x_q;
    assign ball_y      = y_q;
    assign score_a_evt = evt_a_q;
    assign score_b_evt = evt_b_q;
    assign game_state  = state_q;

endmodule
`default_nettype wire
